memo_writer: RTL
================

Name: memo_writer

Overview:
Recording-side counterpart of the audio memory read controller. Accepts a stream of 16-bit audio samples over a valid/ready handshake and writes them sequentially into external memory starting at base+2. On stop, it writes the two-word header that the playback controller consumes:
- word at base = start address
- word at base+1 = end address
Sits between the audio capture path and the shared sample memory.

Parameters:
- WR_WAIT, 2, idle cycles after each write_en pulse before the next memory access (memory write latency)
- ADDR_W, 21, width of addr_out; upper ADDR_W-16 bits always zero

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset
- start  in  1  one-cycle pulse; begins recording at base_addr
- stop  in  1  pulse; ends recording and commits the header
- base_addr  in  16  header location; sampled on accepted start
- sample_in  in  16  audio sample
- sample_valid  in  1  sample_in is valid
- sample_ready  out  1  block accepts a sample this cycle
- write_en  out  1  memory write strobe, one cycle per word
- data_out  out  16  memory write data
- addr_out  out  ADDR_W  memory write address
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the end-address header word is written
- overflow  out  1  sticky; recording stopped because memory region was full

Behaviour:
- Reset: reset synchronous, active-high; clock clock. Reset forces state IDLE, clears stop_pending and the pointers, and drives every output to 0. Reset mid-recording aborts the recording; no header is written.
- States:
  - IDLE: start -> latch base, wr_ptr=base+2, last=base+1, clear overflow -> WAIT_SAMPLE. start is ignored in any other state.
  - WAIT_SAMPLE: sample_ready=1 iff !stop_pending.
    - sample_valid&&sample_ready -> latch sample -> WRITE.
    - else stop_pending -> HDR_START.
  - WRITE: write_en=1, addr_out=wr_ptr, data_out=sample; last<=wr_ptr -> WRITE_WAIT.
  - WRITE_WAIT: counts WR_WAIT cycles, then wr_ptr<=wr_ptr+1.
    - if stop_pending or wr_ptr==16'hFFFF -> HDR_START (full case also sets overflow)
    - else -> WAIT_SAMPLE
  - HDR_START: write_en=1, addr_out=base, data_out=base+2 -> HDR_START_WAIT (WR_WAIT cycles) -> HDR_END.
  - HDR_END: write_en=1, addr_out=base+1, data_out=last -> HDR_END_WAIT (WR_WAIT cycles) -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- stop_pending: set by stop in any state except IDLE; cleared on entry to IDLE.
- Stop and sample in the same cycle: the sample is accepted and written, then recording ends.
- stop in IDLE is ignored.
- Empty recording (stop before any sample): header = {base+2, base+1}. End < start marks the recording as empty.
- Address arithmetic: 16-bit, wrapping. addr_out = zero-extended 16-bit address.
- data_out and addr_out are 0 whenever write_en=0.
- busy=1 in all states except IDLE.
- Latency: sample accepted in cycle N -> write_en in N+1 -> sample_ready high again in N+2+WR_WAIT.
- Throughput: one sample per 2+WR_WAIT cycles.

Optional Feature:
- Macro: MEMO_WRITER_MAXLEN_EN.
- Defined: adds input max_len[15:0], latched on start. Recording auto-stops after max_len samples, behaving exactly as if stop arrived with the last sample; overflow is not set. max_len=0 means unlimited.
- Undefined: port absent; only stop or a full region ends recording.

Decomposition:
- Shared package (memo_pkg): state encoding constants, HDR_START_OFS=0, HDR_END_OFS=1, DATA_OFS=2.
- The playback controller uses the same offsets from memo_pkg.
- One sub-module is natural: memo_wait_cnt, a loadable down-counter producing a wait-done pulse. It is reusable by the read controller.

Test Plan:
- Basic recording: base=0x0100, start, 3 samples 0xAAAA/0xBBBB/0xCCCC, stop.
  -> writes 0x0102=AAAA, 0x0103=BBBB, 0x0104=CCCC, then 0x0100=0x0102, 0x0101=0x0104; done pulses once; busy falls with done.
- Empty recording: start then stop with no samples.
  -> only header writes: 0x0100=0x0102, 0x0101=0x0101.
- Coincident stop: stop in the same cycle as the 2nd valid sample.
  -> 2 samples written, end header = base+3, sample_ready never reasserts.
- Full region: base=0xFFFB, stream continuously.
  -> samples written at 0xFFFD..0xFFFF, overflow=1, header {0xFFFD, 0xFFFF}.
- Reset mid-recording: reset after 1 sample.
  -> all outputs 0 next cycle, no header write, a new start works normally.
- Back-pressure and max length: with MEMO_WRITER_MAXLEN_EN and max_len=2, sample_valid held high.
  -> ready pulses exactly twice spaced 2+WR_WAIT cycles, auto-stop, overflow=0.

Source files
------------

// File: rtl/memo_pkg.sv
// memo_pkg: shared state encodings and header/data offsets for the memo recorder and playback controllers.
package memo_pkg;
   localparam logic [3:0] ST_IDLE           = 4'd0;
   localparam logic [3:0] ST_WAIT_SAMPLE    = 4'd1;
   localparam logic [3:0] ST_WRITE          = 4'd2;
   localparam logic [3:0] ST_WRITE_WAIT     = 4'd3;
   localparam logic [3:0] ST_HDR_START      = 4'd4;
   localparam logic [3:0] ST_HDR_START_WAIT = 4'd5;
   localparam logic [3:0] ST_HDR_END        = 4'd6;
   localparam logic [3:0] ST_HDR_END_WAIT   = 4'd7;
   localparam logic [3:0] ST_DONE           = 4'd8;
   localparam logic [15:0] HDR_START_OFS = 16'd0;
   localparam logic [15:0] HDR_END_OFS   = 16'd1;
   localparam logic [15:0] DATA_OFS      = 16'd2;
   function automatic logic [15:0] ofs_addr(input logic [15:0] base, input logic [15:0] ofs);
      return base + ofs;
   endfunction
endpackage

// File: rtl/memo_wait_cnt.sv
// memo_wait_cnt: loadable down-counter; zero is high once the loaded count has fully elapsed.
module memo_wait_cnt #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
   always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
   assign zero = !load && cnt_q == '0;
endmodule

// File: rtl/memo_writer.sv
// memo_writer: records a 16-bit sample stream to memory at base+2.. and commits a {start,end} header at base.
// Optional MEMO_WRITER_MAXLEN_EN adds max_len auto-stop; WR_WAIT below 1 behaves as 1.
module memo_writer
   import memo_pkg::*;
#(
   parameter int WR_WAIT = 2,
   parameter int ADDR_W  = 21
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [15:0]       base_addr,
   input  logic [15:0]       sample_in,
   input  logic              sample_valid,
`ifdef MEMO_WRITER_MAXLEN_EN
   input  logic [15:0]       max_len,
`endif
   output logic              sample_ready,
   output logic              write_en,
   output logic [15:0]       data_out,
   output logic [ADDR_W-1:0] addr_out,
   output logic              busy,
   output logic              done,
   output logic              overflow
);
   localparam int WAIT_LD = WR_WAIT > 0 ? WR_WAIT - 1 : 0;
   logic [3:0]  state_q, state_d;
   logic [15:0] base_q, base_d, wr_ptr_q, wr_ptr_d, last_q, last_d, sample_q, sample_d;
   logic        stop_pending_q, stop_pending_d, overflow_q, overflow_d;
   logic        wait_zero, accept, auto_stop, full;
   logic [15:0] addr16;
   memo_wait_cnt #(.W(8)) u_wait (
      .clock    (clock),
      .reset    (reset),
      .load     (write_en),
      .load_val (8'(WAIT_LD)),
      .zero     (wait_zero)
   );
   assign accept = state_q == ST_WAIT_SAMPLE && sample_valid && sample_ready;
   assign full   = wr_ptr_q == 16'hFFFF;
`ifdef MEMO_WRITER_MAXLEN_EN
   logic [15:0] max_len_q, max_len_d, count_q, count_d;
   // The last allowed sample raises stop_pending exactly like a coincident stop.
   assign auto_stop = accept && max_len_q != '0 && count_q + 16'd1 == max_len_q;
   always_comb begin
      max_len_d = (state_q == ST_IDLE && start) ? max_len : max_len_q;
      count_d   = (state_q == ST_IDLE && start) ? '0 : (accept ? count_q + 16'd1 : count_q);
   end
   always_ff @(posedge clock) begin
      max_len_q <= reset ? '0 : max_len_d;
      count_q   <= reset ? '0 : count_d;
   end
`else
   assign auto_stop = 1'b0;
`endif
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      wr_ptr_d   = wr_ptr_q;
      last_d     = last_q;
      sample_d   = sample_q;
      overflow_d = overflow_q;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d    = ST_WAIT_SAMPLE;
            base_d     = base_addr;
            wr_ptr_d   = ofs_addr(base_addr, DATA_OFS);
            last_d     = ofs_addr(base_addr, HDR_END_OFS);
            overflow_d = 1'b0;
         end
         ST_WAIT_SAMPLE: if (accept) begin
            sample_d = sample_in;
            state_d  = ST_WRITE;
         end else if (stop_pending_q) state_d = ST_HDR_START;
         ST_WRITE: begin
            last_d  = wr_ptr_q;
            state_d = ST_WRITE_WAIT;
         end
         ST_WRITE_WAIT: if (wait_zero) begin
            wr_ptr_d   = wr_ptr_q + 16'd1;
            state_d    = (stop_pending_q || full) ? ST_HDR_START : ST_WAIT_SAMPLE;
            overflow_d = overflow_q | full;
         end
         ST_HDR_START:      state_d = ST_HDR_START_WAIT;
         ST_HDR_START_WAIT: state_d = wait_zero ? ST_HDR_END : state_q;
         ST_HDR_END:        state_d = ST_HDR_END_WAIT;
         ST_HDR_END_WAIT:   state_d = wait_zero ? ST_DONE : state_q;
         ST_DONE:           state_d = ST_IDLE;
         default:           state_d = ST_IDLE;
      endcase
      stop_pending_d = state_d == ST_IDLE ? 1'b0 : stop_pending_q | (stop && state_q != ST_IDLE) | auto_stop;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         base_q         <= '0;
         wr_ptr_q       <= '0;
         last_q         <= '0;
         sample_q       <= '0;
         stop_pending_q <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         base_q         <= base_d;
         wr_ptr_q       <= wr_ptr_d;
         last_q         <= last_d;
         sample_q       <= sample_d;
         stop_pending_q <= stop_pending_d;
         overflow_q     <= overflow_d;
      end
   end
   assign write_en     = state_q == ST_WRITE || state_q == ST_HDR_START || state_q == ST_HDR_END;
   assign sample_ready = state_q == ST_WAIT_SAMPLE && !stop_pending_q;
   assign busy         = state_q != ST_IDLE;
   assign done         = state_q == ST_DONE;
   assign overflow     = overflow_q;
   assign addr16   = state_q == ST_WRITE     ? wr_ptr_q :
                     state_q == ST_HDR_START ? ofs_addr(base_q, HDR_START_OFS) :
                     state_q == ST_HDR_END   ? ofs_addr(base_q, HDR_END_OFS) : '0;
   assign data_out = state_q == ST_WRITE     ? sample_q :
                     state_q == ST_HDR_START ? ofs_addr(base_q, DATA_OFS) :
                     state_q == ST_HDR_END   ? last_q : '0;
   assign addr_out = ADDR_W'(addr16);
endmodule
